rll_keyed_pipe: RTL

- Parametrised, sequential successor to the team's random-logic-locked (RLL) combinational benchmarks.
- Replaces parallel key pins with a serially loaded key register.
- Key gates are XOR/XNOR-equivalent masking on a DATA_W-wide valid/ready pipeline of STAGES register stages.
- With the correct key the block is a transparent delay line; any other key corrupts outputs in a key-dependent pattern. Used as a locked datapath slice in generated lock benchmarks.

---
 rtl/rll_keyed_pipe.sv | 132 +++++++++++++
 1 files changed

// File: rtl/rll_keyed_pipe.sv
// rll_keyed_pipe: key-locked valid/ready delay line.
// A serially loaded key (MSB first) drives an XOR mask applied when a word
// enters the first stage. With CORRECT_KEY loaded the pipe is transparent.
// Optional macro RLL_KEYED_PIPE_ARMED_ONLY_EN: accept data only once the
// key is fully loaded (otherwise data is also accepted before any load).
module rll_keyed_pipe #(
    parameter int unsigned      DATA_W      = 32,
    parameter int unsigned      KEY_W       = 16,
    parameter int unsigned      STAGES      = 2,
    parameter logic [KEY_W-1:0] CORRECT_KEY = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_start,
    input  logic              key_valid,
    input  logic              key_bit,
    output logic              key_ready,
    output logic              key_loaded,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    localparam int unsigned CNT_W = $clog2(KEY_W);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_LOADING,
        ST_ARMED
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [KEY_W-1:0]  r_key;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_shift;
    logic              w_last_bit;
    logic [KEY_W-1:0]  w_m;
    logic [DATA_W-1:0] w_mask;
    logic              w_adv;
    logic              w_accept_state;
    logic              w_accept;
    logic [STAGES-1:0] r_vld;
    logic [DATA_W-1:0] r_data [STAGES];

    // key_start overrides any key bit presented in the same cycle
    assign w_shift    = (r_state == ST_LOADING) && key_valid && !key_start;
    assign w_last_bit = w_shift && (r_cnt == CNT_W'(KEY_W - 1));

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state: restart load on key_start, arm after the final key bit
    always_comb begin
        w_state_nxt = r_state;
        if (key_start) begin
            w_state_nxt = ST_LOADING;
        end else if (w_last_bit) begin
            w_state_nxt = ST_ARMED;
        end
    end

    // serial key shift register and bit counter (counter stops at the last bit)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_key <= '0;
            r_cnt <= '0;
        end else if (key_start) begin
            r_key <= '0;
            r_cnt <= '0;
        end else if (w_shift) begin
            r_key <= {r_key[KEY_W-2:0], key_bit};
            if (!w_last_bit) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign key_ready  = (r_state == ST_LOADING);
    assign key_loaded = (r_state == ST_ARMED);

    assign w_m = r_key ^ CORRECT_KEY;

    // mask: key MSB lands on data bit 0, pattern repeats every KEY_W bits
    always_comb begin
        w_mask = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            w_mask[i] = w_m[KEY_W - 1 - (i % KEY_W)];
        end
    end

    assign w_adv = !r_vld[STAGES-1] || out_ready;

`ifdef RLL_KEYED_PIPE_ARMED_ONLY_EN
    assign w_accept_state = (r_state == ST_ARMED);
`else
    assign w_accept_state = (r_state != ST_LOADING);
`endif

    assign in_ready = w_adv && w_accept_state;
    assign w_accept = in_valid && in_ready;

    // pipeline: all stages shift together on advance, hold entirely on stall
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int unsigned s = 0; s < STAGES; s++) begin
                r_data[s] <= '0;
            end
        end else if (w_adv) begin
            r_vld[0]  <= w_accept;
            r_data[0] <= w_accept ? (in_data ^ w_mask) : '0;
            for (int unsigned s = 1; s < STAGES; s++) begin
                r_vld[s]  <= r_vld[s-1];
                r_data[s] <= r_data[s-1];
            end
        end
    end

    assign out_valid = r_vld[STAGES-1];
    assign out_data  = r_data[STAGES-1];

endmodule
